// File: rtl/mips_pipe_pkg.sv
// Shared constants for the mipspipe_mp3 pipeline: the NOP pad word and the
// instruction-memory loader state encoding.
package mips_pipe_pkg;

    // add $0,$0,$0
    localparam logic [31:0] NOP = 32'h00000020;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } loader_state_e;

endpackage

// File: rtl/mips_imem_loader.sv
// Streams a program into the instruction memory from word 0, pads the rest of
// the depth with NOPs, then raises run to release the pipeline.
module mips_imem_loader
    import mips_pipe_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int WORD_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    // valid/ready: a word transfers on every rising edge where in_valid and
    // in_ready are both high; in_ready depends only on state, never on in_valid.
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_word,
    input  logic              in_last,
    output logic              in_ready,
    input  logic              reload,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic [ADDR_W:0]   load_count,
    output logic              run,
    output logic              overflow,
    output logic [1:0]        dbg_state
);

    localparam int              DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W:0] LAST_PTR = (ADDR_W + 1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] PTR_ONE  = (ADDR_W + 1)'(1);
    localparam logic [WORD_W-1:0] PAD    = WORD_W'(NOP);

    loader_state_e     state_q;
    logic [ADDR_W:0]   wptr_q;
    logic [ADDR_W:0]   count_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [WORD_W-1:0] mem_wdata_q;
    logic              run_q;
    logic              overflow_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= LOAD;
            wptr_q      <= '0;
            count_q     <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            run_q       <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            case (state_q)
                LOAD: begin
                    if (in_valid) begin
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= wptr_q[ADDR_W-1:0];
                        mem_wdata_q <= in_word;
                        wptr_q      <= wptr_q + PTR_ONE;
                        count_q     <= count_q + PTR_ONE;
                        // A full image ends the load even without in_last.
                        if (wptr_q == LAST_PTR) begin
                            state_q <= DONE;
                        end else if (in_last) begin
                            state_q <= FILL;
                        end
                    end else begin
                        mem_we_q <= 1'b0;
                    end
                end
                FILL: begin
                    mem_we_q    <= 1'b1;
                    mem_addr_q  <= wptr_q[ADDR_W-1:0];
                    mem_wdata_q <= PAD;
                    wptr_q      <= wptr_q + PTR_ONE;
                    if (wptr_q == LAST_PTR) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    mem_we_q <= 1'b0;
                    if (reload) begin
                        state_q    <= LOAD;
                        wptr_q     <= '0;
                        count_q    <= '0;
                        run_q      <= 1'b0;
                        overflow_q <= 1'b0;
                    end else begin
                        run_q <= 1'b1;
                        if (in_valid) begin
                            overflow_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q  <= LOAD;
                    mem_we_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = (state_q == LOAD);
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign load_count = count_q;
    assign run        = run_q;
    assign overflow   = overflow_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_mips_imem_loader.sv
// Directed bench for mips_imem_loader at ADDR_W=3: a write scoreboard fed by
// the stimulus tasks, plus status checks at the load boundaries.
module tb_mips_imem_loader;

    localparam int ADDR_W = 3;
    localparam int WORD_W = 32;
    localparam logic [31:0] NOP_W = 32'h00000020;

    logic              clock;
    logic              reset;
    logic              in_valid;
    logic [WORD_W-1:0] in_word;
    logic              in_last;
    logic              in_ready;
    logic              reload;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata;
    logic [ADDR_W:0]   load_count;
    logic              run;
    logic              overflow;
    logic [1:0]        dbg_state;

    int n_assert = 0;
    int n_fail   = 0;

    logic [ADDR_W+WORD_W-1:0] exp_q[$];
    logic [3:0]               m_wptr;
    logic                     m_loading;

    mips_imem_loader #(.ADDR_W(ADDR_W), .WORD_W(WORD_W)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_word    (in_word),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .reload     (reload),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .load_count (load_count),
        .run        (run),
        .overflow   (overflow),
        .dbg_state  (dbg_state)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every write on the memory port must match the next expected entry.
    always @(negedge clock) begin
        if (mem_we === 1'b1) begin
            check("write_expected", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
                logic [ADDR_W+WORD_W-1:0] e;
                e = exp_q.pop_front();
                check("write_addr", 64'(mem_addr), 64'(e[ADDR_W+WORD_W-1:WORD_W]));
                check("write_data", 64'(mem_wdata), 64'(e[WORD_W-1:0]));
            end
        end
    end

    task automatic model_restart();
        m_wptr    = '0;
        m_loading = 1'b1;
    endtask

    // Drive one cycle of input; expected writes are queued when a word is accepted.
    task automatic drive(input logic v, input logic [31:0] w, input logic l);
        in_valid = v;
        in_word  = w;
        in_last  = l;
        if (v && m_loading) begin
            exp_q.push_back({m_wptr[2:0], w});
            m_wptr++;
            if (m_wptr == 4'd8) begin
                m_loading = 1'b0;
            end else if (l) begin
                m_loading = 1'b0;
                while (m_wptr < 4'd8) begin
                    exp_q.push_back({m_wptr[2:0], NOP_W});
                    m_wptr++;
                end
            end
        end
        @(negedge clock);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (n) @(negedge clock);
    endtask

    task automatic do_reload();
        reload = 1'b1;
        @(negedge clock);
        reload = 1'b0;
        model_restart();
    endtask

    initial begin
        logic [31:0] w;
        reset = 1'b0; in_valid = 1'b0; in_word = '0; in_last = 1'b0; reload = 1'b0;
        model_restart();

        // 1: asynchronous reset before any clock edge
        #2 reset = 1'b1;
        #1;
        check("rst_mem_we",   64'(mem_we), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_wdata",    64'(mem_wdata), 64'd0);
        check("rst_count",    64'(load_count), 64'd0);
        check("rst_run",      64'(run), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_state",    64'(dbg_state), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("rst_ready", 64'(in_ready), 64'd1);

        // 2: three words, last on the third, then NOP fill
        drive(1'b1, 32'hAAAA0001, 1'b0);
        drive(1'b1, 32'hBBBB0002, 1'b0);
        drive(1'b1, 32'hCCCC0003, 1'b1);
        check("t2_fill_state", 64'(dbg_state), 64'd1);
        check("t2_fill_ready", 64'(in_ready), 64'd0);
        idle(5);
        check("t2_run_early", 64'(run), 64'd0);
        idle(1);
        check("t2_run",       64'(run), 64'd1);
        check("t2_mem_we",    64'(mem_we), 64'd0);
        check("t2_count",     64'(load_count), 64'd3);
        check("t2_state",     64'(dbg_state), 64'd2);
        check("t2_q_empty",   64'(exp_q.size()), 64'd0);

        // 3: gaps in in_valid
        do_reload();
        check("t3_ready", 64'(in_ready), 64'd1);
        drive(1'b1, 32'h11110000, 1'b0);
        drive(1'b0, 32'hDEADDEAD, 1'b0);
        drive(1'b0, 32'hDEADDEAD, 1'b1);
        drive(1'b1, 32'h22220000, 1'b0);
        drive(1'b1, 32'h33330000, 1'b1);
        idle(6);
        check("t3_run",     64'(run), 64'd1);
        check("t3_count",   64'(load_count), 64'd3);
        check("t3_q_empty", 64'(exp_q.size()), 64'd0);

        // 4: full depth without in_last, then a word that must be refused
        do_reload();
        for (int i = 0; i < 8; i++) begin
            w = $urandom_range(32'h7FFFFFFF, 0);
            drive(1'b1, w, 1'b0);
        end
        check("t4_state_done", 64'(dbg_state), 64'd2);
        check("t4_ready",      64'(in_ready), 64'd0);
        check("t4_run_early",  64'(run), 64'd0);
        check("t4_count",      64'(load_count), 64'd8);
        drive(1'b1, 32'hBADBAD00, 1'b0);
        check("t4_run",        64'(run), 64'd1);
        check("t4_overflow",   64'(overflow), 64'd1);
        check("t4_mem_we",     64'(mem_we), 64'd0);
        idle(2);
        check("t4_ovf_sticky", 64'(overflow), 64'd1);
        check("t4_q_empty",    64'(exp_q.size()), 64'd0);

        // 5: reload clears status, short load refills
        do_reload();
        check("t5_run",      64'(run), 64'd0);
        check("t5_overflow", 64'(overflow), 64'd0);
        check("t5_count",    64'(load_count), 64'd0);
        check("t5_ready",    64'(in_ready), 64'd1);
        drive(1'b1, 32'h55550001, 1'b0);
        drive(1'b1, 32'h55550002, 1'b1);
        idle(7);
        check("t5_run_done", 64'(run), 64'd1);
        check("t5_count2",   64'(load_count), 64'd2);
        check("t5_q_empty",  64'(exp_q.size()), 64'd0);

        // 6: reset during fill with wptr at 5
        do_reload();
        drive(1'b1, 32'h66660001, 1'b0);
        drive(1'b1, 32'h66660002, 1'b1);
        idle(3);
        check("t6_fill_addr", 64'(mem_addr), 64'd4);
        #2 reset = 1'b1;
        #1;
        check("t6_mem_we", 64'(mem_we), 64'd0);
        check("t6_state",  64'(dbg_state), 64'd0);
        check("t6_count",  64'(load_count), 64'd0);
        exp_q.delete();
        @(negedge clock);
        reset = 1'b0;
        model_restart();
        drive(1'b1, 32'h77770001, 1'b1);
        idle(8);
        check("t6_run",     64'(run), 64'd1);
        check("t6_count2",  64'(load_count), 64'd1);
        check("t6_q_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
